// File: rtl/contador_updown_bcd_pkg.sv
// Shared types and helpers for the up/down BCD counter slice.
// Holds the converter state encoding and the digit-count check used at elaboration.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int SYNC_STAGES = 2;

  // Smallest number of decimal digits that can show 2^n-1.
  function automatic int digits_needed(input int n);
    longint unsigned max_v;
    longint unsigned limit;
    int              d;
    max_v = (64'd1 << n) - 64'd1;
    limit = 64'd1;
    d     = 0;
    while (limit <= max_v) begin
      limit = limit * 64'd10;
      d     = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/contador_updown_bcd_bin_to_bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, N+1 cycles from capture to bcd.
// 'start' flags a new value on 'bin'; 'done' is high while bcd matches the latest request.
module bin_to_bcd_seq
  import contador_pkg::*;
#(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N-1:0]        bin,
  output logic [4*DIGITS-1:0] bcd,
  output logic                done
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_SHIFT = CW'(N - 1);

  conv_state_t   state_q, state_d;
  logic          pending_q, pending_d;
  logic [SW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] shcnt_q, shcnt_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic          done_q, done_d;
  logic          capture_s, shift_s, finish_s;
  logic [SW-1:0] adj_s;

  function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] digits);
    logic [BW-1:0] adj;
    adj = digits;
    for (int k = 0; k < DIGITS; k++) begin
      if (digits[4*k +: 4] >= 4'd5) adj[4*k +: 4] = digits[4*k +: 4] + 4'd3;
      else                          adj[4*k +: 4] = digits[4*k +: 4];
    end
    return adj;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending_q) state_d = SHIFT; else state_d = IDLE;
      SHIFT:   if (shcnt_q == LAST_SHIFT) state_d = DONE; else state_d = SHIFT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture_s = 1'b0;
    shift_s   = 1'b0;
    finish_s  = 1'b0;
    case (state_q)
      IDLE:    capture_s = pending_q;
      SHIFT:   shift_s   = 1'b1;
      DONE:    finish_s  = 1'b1;
      default: capture_s = 1'b0;
    endcase
  end

  // A new request always wins over the capture that clears it, so a write in the capture cycle is re-run.
  always_comb begin
    adj_s     = {dabble_adjust(shreg_q[SW-1:N]), shreg_q[N-1:0]};
    shreg_d   = shreg_q;
    shcnt_d   = shcnt_q;
    bcd_d     = bcd_q;
    pending_d = pending_q;
    done_d    = done_q;
    if (capture_s) begin
      shreg_d = {{BW{1'b0}}, bin};
      shcnt_d = {CW{1'b0}};
    end else if (shift_s) begin
      shreg_d = {adj_s[SW-2:0], 1'b0};
      shcnt_d = shcnt_q + CW'(1);
    end else if (finish_s) begin
      bcd_d = shreg_q[SW-1:N];
    end else begin
      shreg_d = shreg_q;
    end
    if (start)          pending_d = 1'b1;
    else if (capture_s) pending_d = 1'b0;
    else                pending_d = pending_q;
    if (start)          done_d = 1'b0;
    else if (finish_s)  done_d = ~pending_q;
    else                done_d = done_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q   <= {SW{1'b0}};
      shcnt_q   <= {CW{1'b0}};
      bcd_q     <= {BW{1'b0}};
      pending_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      shcnt_q   <= shcnt_d;
      bcd_q     <= bcd_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;

endmodule

// File: rtl/contador_updown_bcd.sv
// N-bit up/down counter fed by synchronised buttons, with load, wrap/saturate and BCD output.
// Define CONTADOR_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES-sample debouncer after each synchroniser.
module contador_updown_bcd
  import contador_pkg::*;
#(
  parameter int N               = 8,
  parameter int DIGITS          = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                load,
  input  logic [N-1:0]        data_in,
  input  logic                wrap_mode,
  output logic [N-1:0]        count,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                bcd_valid,
  output logic                ovf,
  output logic                unf
);

  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
  localparam logic [N-1:0] CNT_MIN = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE = N'(1'b1);

  if (DIGITS < digits_needed(N)) begin : g_digits_chk
    $error("contador_updown_bcd: DIGITS too small to show 2^N-1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_chk
    $error("contador_updown_bcd: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [1:0]                  btn_raw_s;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0]                  stable_s;
  logic [1:0]                  stable_prev_q;
  logic [1:0]                  edge_s;
  logic                        up_s, dn_s, write_s;
  logic [N-1:0]                count_q, count_d;
  logic                        ovf_q, ovf_d, unf_q, unf_d;
  logic [4*DIGITS-1:0]         bcd_s;
  logic                        done_s;

  assign btn_raw_s = {btn_down, btn_up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '{default: {SYNC_STAGES{1'b0}}};
    end else begin
      for (int b = 0; b < 2; b++) sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], btn_raw_s[b]};
    end
  end

`ifdef CONTADOR_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]          db_level_q, db_level_d;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples disagreeing with it.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    for (int b = 0; b < 2; b++) begin
      if (sync_q[b][SYNC_STAGES-1] != db_level_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          db_level_d[b] = ~db_level_q[b];
          db_cnt_d[b]   = {DBW{1'b0}};
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DBW'(1);
        end
      end else begin
        db_cnt_d[b] = {DBW{1'b0}};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q   <= '{default: {DBW{1'b0}}};
      db_level_q <= 2'b00;
    end else begin
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
    end
  end

  assign stable_s = db_level_q;
`else
  always_comb begin
    for (int b = 0; b < 2; b++) stable_s[b] = sync_q[b][SYNC_STAGES-1];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stable_prev_q <= 2'b00;
    else     stable_prev_q <= stable_s;
  end

  assign edge_s = stable_s & ~stable_prev_q;
  assign up_s   = edge_s[0] & ~edge_s[1];
  assign dn_s   = edge_s[1] & ~edge_s[0];

  // Load beats a button step; a saturated step still counts as a write so the BCD is refreshed.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    write_s = 1'b0;
    if (load) begin
      count_d = data_in;
      write_s = 1'b1;
    end else if (up_s) begin
      write_s = 1'b1;
      if (count_q == CNT_MAX) begin
        ovf_d   = 1'b1;
        count_d = wrap_mode ? CNT_MIN : CNT_MAX;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else if (dn_s) begin
      write_s = 1'b1;
      if (count_q == CNT_MIN) begin
        unf_d   = 1'b1;
        count_d = wrap_mode ? CNT_MAX : CNT_MIN;
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= CNT_MIN;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  bin_to_bcd_seq #(
    .N      (N),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (write_s),
    .bin   (count_q),
    .bcd   (bcd_s),
    .done  (done_s)
  );

  assign count     = count_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign bcd_out   = bcd_s;
  assign bcd_valid = done_s;

endmodule

// File: doc/contador_updown_bcd.md
Name: contador_updown_bcd

Overview:
- Parametrised successor of the single-button down-counter display path.
- N-bit up/down counter with synchronised button inputs, synchronous parallel load and a selectable wrap or saturate mode.
- Includes a sequential (double-dabble) binary-to-BCD converter with a valid flag.
- Sits between board switches/buttons and the 7-segment decoder stage; bcd_out feeds per-digit decoders.

Parameters:
- N, 8, counter width in bits.
- DIGITS, 3, BCD output digits; must satisfy 10^DIGITS > 2^N-1. Elaboration error otherwise.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples needed to accept a button level (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_up  in  1  increment button, asynchronous to clk.
- btn_down  in  1  decrement button, asynchronous to clk.
- load  in  1  synchronous load strobe, already in the clk domain.
- data_in  in  N  load value (switches).
- wrap_mode  in  1  1 = modular wrap, 0 = saturate at 0 and 2^N-1.
- count  out  N  current counter value.
- bcd_out  out  4*DIGITS  BCD of last converted count; digit k at [4k+3:4k], digit 0 = units.
- bcd_valid  out  1  high when bcd_out matches count and no conversion is pending.
- ovf  out  1  one-cycle pulse on increment attempted at 2^N-1.
- unf  out  1  one-cycle pulse on decrement attempted at 0.

Behaviour:
- Reset values:
  - count=0, bcd_out=0, bcd_valid=0, ovf=0, unf=0.
  - Synchronisers and edge registers = 0.
  - Converter FSM = IDLE with pending=1, so a conversion of 0 runs after reset release.
- Button path: each button uses a 2-flop synchroniser, then edge detection (stable & ~stable_d).
  - Without debounce, count changes on the 3rd rising clk edge after the button rises.
  - Held buttons produce exactly one step; release produces nothing.
- Priority per cycle: load > (up XOR down) > hold.
  - Up and down edges in the same cycle cancel: no change, no ovf/unf.
  - load with an edge in the same cycle: count=data_in and the edge is discarded.
- Increment at 2^N-1:
  - wrap_mode=1: count becomes 0, ovf=1.
  - wrap_mode=0: count held, ovf=1.
- Decrement at 0: symmetric; wraps to 2^N-1 or holds, and unf=1.
- Any cycle where count is written (load or step, even if the value is unchanged) sets pending=1 and drives bcd_valid=0 on the next edge.
- Converter FSM:
  - IDLE: if pending, capture count into the shift register, clear the BCD scratch, clear pending, go to SHIFT.
  - SHIFT: N cycles. Each cycle, add 3 to every scratch digit >=5, then shift the {scratch, bin} register left 1. After the Nth shift go to DONE.
  - DONE: bcd_out <= scratch; bcd_valid <= ~pending; go to IDLE.
  - Latency from capture edge to bcd_out update: N+1 cycles.
- Count change during SHIFT:
  - The conversion completes with the old value and bcd_out updates, but bcd_valid stays 0.
  - IDLE immediately restarts on the new value. No corrupted intermediate values reach bcd_out.
- Reset mid-operation: all state returns to reset values on rst assertion, independent of clk.

Optional Feature:
- Macro CONTADOR_DEBOUNCE_EN.
  - Defined: after synchronisation, each button has a counter. The stable level toggles only after DEBOUNCE_CYCLES consecutive identical samples differing from the current stable level; any mismatch resets the counter. Added latency is DEBOUNCE_CYCLES cycles.
  - Undefined: the synchroniser output is the stable level directly; DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package contador_pkg:
  - Enum conv_state_t {IDLE, SHIFT, DONE}.
  - Function digits_needed(N) for the elaboration check.
  - Localparam SYNC_STAGES=2.
- Sub-module bin_to_bcd_seq (parameters N, DIGITS): ports clk, rst, start, bin, bcd, done. Holds the FSM and scratch register.
- Counter, synchroniser and debounce logic live in the top module.

Test Plan:
- Reset release, no stimulus -> count=0; after N+2 cycles bcd_out=12'h000, bcd_valid=1.
- load=1 with data_in=8'd199 for 1 cycle -> count=199; bcd_valid low, then high with bcd_out=12'h199 N+2 cycles later.
- count=255, wrap_mode=0, btn_up pulse -> count stays 255, one-cycle ovf. Repeat with wrap_mode=1 -> count=0, ovf pulse, bcd_out=12'h000.
- count=0, wrap_mode=1, btn_down -> count=255, unf pulse, bcd_out=12'h255. btn_up and btn_down rising in the same cycle -> count unchanged, no pulses.
- Count 42 converting; btn_up lands during SHIFT -> bcd_out briefly 12'h042 with bcd_valid=0, then 12'h043 with bcd_valid=1.
- With CONTADOR_DEBOUNCE_EN: a btn_up glitch shorter than 16 cycles -> no change; a 20-cycle press -> exactly one increment.
